// File: rtl/posit_extract_pipe.sv
// Two-stage posit field extractor: splits a posit word into sign, regime k, exponent and mantissa.
// Optional zero/NaR transfer counters are enabled by defining POSIT_EXTRACT_STATS_EN.
module posit_extract_pipe #(
  parameter int N     = 32,
  parameter int ES    = 2,
  parameter int RS    = $clog2(N),
  parameter int TAG_W = 4,
  localparam int EW   = (ES > 0) ? ES : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        in_data,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TAG_W-1:0]    out_tag,
  output logic                sign,
  output logic signed [RS:0]  k,
  output logic [EW-1:0]       exponent,
  output logic [N-1:0]        mantissa,
  output logic                inf,
  output logic                zero
`ifdef POSIT_EXTRACT_STATS_EN
  ,
  input  logic                stats_clr,
  output logic [15:0]         zero_count,
  output logic [15:0]         nar_count
`endif
);

  logic               r_s1_valid;
  logic               r_s1_sign;
  logic               r_s1_zero;
  logic               r_s1_nar;
  logic               r_s1_pol;
  logic [RS-1:0]      r_s1_run;
  logic [N-2:0]       r_s1_body;
  logic [TAG_W-1:0]   r_s1_tag;

  logic               r_s2_valid;
  logic               r_s2_sign;
  logic               r_s2_zero;
  logic               r_s2_nar;
  logic signed [RS:0] r_s2_k;
  logic [EW-1:0]      r_s2_exp;
  logic [N-1:0]       r_s2_mant;
  logic [TAG_W-1:0]   r_s2_tag;

  logic               w_s2_adv;
  logic               w_in_fire;
  logic [N-2:0]       w_body;
  logic               w_pol;
  logic [RS-1:0]      w_run;
  logic               w_stop;

  // Handshake depends only on stage state and out_ready, never on in_valid.
  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_adv;
  assign w_in_fire = in_valid && in_ready;

  // Low N-1 bits of |in_data|: negation's low bits depend only on the low input bits.
  assign w_body = in_data[N-1] ? (~in_data[N-2:0] + (N-1)'(1)) : in_data[N-2:0];

  // NOTE: every variable assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_pol  = w_body[N-2];
    w_run  = '0;
    w_stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!w_stop && (w_body[i] == w_pol)) begin
        w_run = w_run + RS'(1);
      end else begin
        w_stop = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
      end
    end
  end

  // NOTE: stage-1 payload needs no reset; it is only observed once r_s1_valid
  // qualifies it, which saves reset routing on the wide datapath.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_s1_sign <= in_data[N-1];
      r_s1_zero <= (in_data == '0);
      r_s1_nar  <= (in_data == {1'b1, {(N-1){1'b0}}});
      r_s1_pol  <= w_pol;
      r_s1_run  <= w_run;
      r_s1_body <= w_body;
      r_s1_tag  <= in_tag;
    end
  end

  logic [RS:0]        w_shamt;
  logic [N-2:0]       w_rem;
  logic [N-2:0]       w_frac;
  logic signed [RS:0] w_run_s;
  logic signed [RS:0] w_k;
  logic [EW-1:0]      w_exp;
  logic               w_special;

  // Shifting out the run plus its terminator leaves exponent bits at the top,
  // with zero fill wherever the word was truncated.
  assign w_shamt   = {1'b0, r_s1_run} + (RS+1)'(1);
  assign w_rem     = r_s1_body << w_shamt;
  assign w_frac    = w_rem << ES;
  assign w_run_s   = $signed({1'b0, r_s1_run});
  assign w_k       = r_s1_pol ? (w_run_s - signed'((RS+1)'(1))) : -w_run_s;
  assign w_special = r_s1_zero || r_s1_nar;

  generate
    if (ES > 0) begin : g_exp
      assign w_exp = w_rem[N-2 -: EW];
    end else begin : g_no_exp
      assign w_exp = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_sign <= 1'b0;
      r_s2_zero <= 1'b0;
      r_s2_nar  <= 1'b0;
      r_s2_k    <= '0;
      r_s2_exp  <= '0;
      r_s2_mant <= '0;
      r_s2_tag  <= '0;
    end else if (w_s2_adv && r_s1_valid) begin
      r_s2_sign <= r_s1_sign;
      r_s2_zero <= r_s1_zero;
      r_s2_nar  <= r_s1_nar;
      r_s2_tag  <= r_s1_tag;
      r_s2_k    <= w_special ? '0 : w_k;
      r_s2_exp  <= w_special ? '0 : w_exp;
      r_s2_mant <= w_special ? '0 : {1'b1, w_frac};
    end
  end

  assign out_valid = r_s2_valid;
  assign out_tag   = r_s2_tag;
  assign sign      = r_s2_sign;
  assign k         = r_s2_k;
  assign exponent  = r_s2_exp;
  assign mantissa  = r_s2_mant;
  assign inf       = r_s2_nar;
  assign zero      = r_s2_zero;

`ifdef POSIT_EXTRACT_STATS_EN
  logic w_out_fire;
  assign w_out_fire = r_s2_valid && out_ready;

  // Saturating counters; a clear request takes priority over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_count <= '0;
      nar_count  <= '0;
    end else if (stats_clr) begin
      zero_count <= '0;
      nar_count  <= '0;
    end else if (w_out_fire) begin
      if (r_s2_zero && (zero_count != 16'hFFFF)) begin
        zero_count <= zero_count + 16'd1;
      end
      if (r_s2_nar && (nar_count != 16'hFFFF)) begin
        nar_count <= nar_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_posit_extract_pipe.sv
// Self-checking bench for posit_extract_pipe (N=32, ES=2): directed literal vectors,
// stall/reset scenarios and a randomized stream scored against a bit-list posit decoder.
module tb_posit_extract_pipe;
  localparam int N     = 32;
  localparam int ES    = 2;
  localparam int RS    = 5;
  localparam int TAG_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       in_data;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [TAG_W-1:0]   out_tag;
  logic               sign;
  logic signed [RS:0] k;
  logic [ES-1:0]      exponent;
  logic [N-1:0]       mantissa;
  logic               inf;
  logic               zero;

  posit_extract_pipe #(.N(N), .ES(ES), .RS(RS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .sign(sign), .k(k), .exponent(exponent), .mantissa(mantissa),
    .inf(inf), .zero(zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [N+TAG_W-1:0] exp_q[$];
  logic [47:0] held;
  logic        have_hold = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Decode by walking the bits after the sign as a list: regime run, terminator,
  // ES exponent bits, then whatever fraction bits remain.
  function automatic logic [47:0] model(input logic [N-1:0] w, input logic [TAG_W-1:0] t);
    logic         s;
    logic [N-1:0] a;
    logic [N-1:0] mant;
    logic         b[N-1];
    int           r, pos, k_m, ex;
    s  = w[N-1];
    ex = 0;
    if (w == 32'h0)        return {1'b1, t, s, 6'd0, 2'd0, 32'd0, 1'b0, 1'b1};
    if (w == 32'h80000000) return {1'b1, t, s, 6'd0, 2'd0, 32'd0, 1'b1, 1'b0};
    a = s ? (32'd0 - w) : w;
    for (int j = 0; j < N - 1; j++) b[j] = a[N-2-j];
    r = 1;
    while (r < N - 1 && b[r] == b[0]) r++;
    k_m = b[0] ? r - 1 : -r;
    pos = r + 1;
    for (int e = 0; e < ES; e++) begin
      ex = ex * 2 + ((pos < N - 1) ? int'(b[pos]) : 0);
      pos++;
    end
    mant = 32'h80000000;
    for (int f = 0; pos + f < N - 1; f++) mant[N-2-f] = b[pos+f];
    return {1'b1, t, s, 6'(k_m), 2'(ex), mant, 1'b0, 1'b0};
  endfunction

  function automatic logic [N-1:0] gen_word();
    int r;
    r = $urandom_range(0, 31);
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF >> r;
      3:       return ~(32'hFFFFFFFF >> r);
      default: return $urandom;
    endcase
  endfunction

  wire [47:0] act = {out_valid, out_tag, sign, k, exponent, mantissa, inf, zero};

  // Scoreboard and protocol monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      have_hold = 1'b0;
    end else begin
      check("in_ready", {63'd0, in_ready}, {63'd0, (exp_q.size() < 2) || out_ready});
      if (have_hold) check("hold_stable", {16'd0, act}, {16'd0, held});
      if (out_valid && !out_ready) begin
        held      = act;
        have_hold = 1'b1;
      end else begin
        have_hold = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got tag %h expected no output", out_tag);
        end else begin
          logic [N+TAG_W-1:0] e;
          e = exp_q.pop_front();
          check("out_word", {16'd0, act}, {16'd0, model(e[N-1:0], e[N+TAG_W-1:N])});
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back({in_tag, in_data});
    end
  end

  // Single word into an empty pipe; checks 2-cycle latency and literal fields.
  task automatic directed(input string name, input logic [N-1:0] d, input logic [42:0] exp_f);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_tag    = 4'hA;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_lat1"}, {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    check({name, "_lat2"}, {63'd0, out_valid}, 64'd1);
    check(name, {21'd0, sign, k, exponent, mantissa, inf, zero}, {21'd0, exp_f});
    @(posedge clk); #1;
  endtask

  initial begin
    int          sent, cyc_i, base;
    logic        go, saw_not_ready, acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    #1;
    check("rst_outputs", {16'd0, act}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Model pinned against hand-decoded words
    check("model_55", {16'd0, model(32'h55555555, 4'h0)},
          {16'd0, 1'b1, 4'h0, 1'b0, 6'd0, 2'b10, 32'hD5555550, 2'b00});
    check("model_ff", {16'd0, model(32'hFFFFFFFF, 4'h3)},
          {16'd0, 1'b1, 4'h3, 1'b1, 6'h22, 2'b00, 32'h80000000, 2'b00});

    directed("w55555555", 32'h55555555, {1'b0, 6'd0,  2'b10, 32'hD5555550, 2'b00});
    directed("w775555FF", 32'h775555FF, {1'b0, 6'd2,  2'b11, 32'hD5557FC0, 2'b00});
    directed("wFFFFFFFF", 32'hFFFFFFFF, {1'b1, 6'h22, 2'b00, 32'h80000000, 2'b00});
    directed("w7FFFFFFF", 32'h7FFFFFFF, {1'b0, 6'd30, 2'b00, 32'h80000000, 2'b00});

    // Zero then NaR back-to-back
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h0;
    @(posedge clk); #1;
    in_data = 32'h80000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("zero_word", {21'd0, sign, k, exponent, mantissa, inf, zero},
          {21'd0, 1'b0, 6'd0, 2'd0, 32'd0, 1'b0, 1'b1});
    @(posedge clk); #1;
    check("nar_word", {21'd0, sign, k, exponent, mantissa, inf, zero},
          {21'd0, 1'b1, 6'd0, 2'd0, 32'd0, 1'b1, 1'b0});
    @(posedge clk); #1;

    // Eight tagged words with a 5-cycle downstream stall mid-stream
    sent = 0; cyc_i = 0; base = n_out; saw_not_ready = 1'b0;
    while (sent < 8 && cyc_i < 100) begin
      in_valid  = 1'b1;
      in_data   = $urandom;
      in_tag    = sent[TAG_W-1:0];
      out_ready = !(cyc_i >= 3 && cyc_i < 8);
      #1 go = in_ready;
      if (!go) saw_not_ready = 1'b1;
      @(posedge clk); #1;
      if (go) sent++;
      cyc_i++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 30 && (n_out - base) < 8; c++) begin
      @(posedge clk); #1;
    end
    check("stall_in_ready_low", {63'd0, saw_not_ready}, 64'd1);
    check("stall_all_out", 64'(n_out - base), 64'd8);

    // Reset with two words in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = $urandom;
    in_tag    = 4'h1;
    @(posedge clk); #1;
    in_data = $urandom;
    in_tag  = 4'h2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_no_emit", {63'd0, out_valid}, 64'd0);
    end
    directed("post_rst", 32'h55555555, {1'b0, 6'd0, 2'b10, 32'hD5555550, 2'b00});

    // Randomized stream with random backpressure; source holds a word until taken
    acc = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = gen_word();
        in_tag   = TAG_W'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1 acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/posit_extract_pipe.md
POSIT_EXTRACT_PIPE -- requirements
Module: posit_extract_pipe

Interface
REQ-001 SHALL have parameter N, default 32, posit word width (legal 8..64).
REQ-002 SHALL have parameter ES, default 2, exponent field width (legal 0..4; ES=0 drives exponent port as 1'b0).
REQ-003 SHALL have parameter RS, default $clog2(N), regime count width; k port is RS+1 bits signed.
REQ-004 SHALL have parameter TAG_W, default 4, sideband tag width carried alongside each word.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  upstream word present; in_ready  output  1  block accepts this cycle.
REQ-008 in_data  input  N  posit word; in_tag  input  TAG_W  sideband tag.
REQ-009 out_valid  output  1  result present; out_ready  input  1  downstream accepts.
REQ-010 out_tag  output  TAG_W; sign  output  1; k  output  RS+1 signed regime value.
REQ-011 exponent  output  max(ES,1); mantissa  output  N, hidden bit at MSB, fraction left-aligned, zero-padded.
REQ-012 inf  output  1  NaR flag; zero  output  1  zero flag.

Function
REQ-013 Transfer in on in_valid&&in_ready; transfer out on out_valid&&out_ready.
REQ-014 Two-stage pipeline, latency exactly 2 cycles from accept to out_valid when unstalled; throughput 1 word/cycle.
REQ-015 Stage 1: register sign=in_data[N-1], absolute value (two's complement when sign=1), zero (in_data==0), NaR (in_data=={1,0...}), leading-run length m and run polarity of bits N-2 downward of absolute value, tag.
REQ-016 Stage 2: k=m-1 for run of ones, k=-m for run of zeros; skip terminator bit; exponent = next ES bits, zero-filled where truncated; mantissa = {1, remaining bits, zero pad}.
REQ-017 Zero or NaR word: k=0, exponent=0, mantissa=0, sign=in_data[N-1], respective flag=1.
REQ-018 Run reaching bit 0 (no terminator): k=N-2 (ones) or -(N-1) (zeros), exponent=0, mantissa={1,0...}.
REQ-019 Stall: stage holding valid data keeps all registers stable while next stage cannot accept; in_ready = !s1_valid || s2_advance, s2_advance = !out_valid || out_ready.
REQ-020 Simultaneous accept and drain in a full pipe SHALL lose and duplicate nothing; order preserved.
REQ-021 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 in_ready SHALL not depend combinationally on in_valid.

Reset
REQ-023 rst=1 SHALL asynchronously clear both stage valid bits; out_valid=0, in_ready=1 during and after reset.
REQ-024 Reset values: sign=0, k=0, exponent=0, mantissa=0, inf=0, zero=0, out_tag=0.
REQ-025 Reset mid-stream discards all in-flight words; first word accepted after release appears 2 cycles later.

Configuration
REQ-026 Macro POSIT_EXTRACT_STATS_EN, when defined, adds input stats_clr (1) and outputs zero_count, nar_count (16 each).
REQ-027 With macro: counters increment on each output transfer with zero=1 / inf=1, saturate at 16'hFFFF, clear to 0 on rst or stats_clr (clear wins over increment).
REQ-028 Without macro: ports and counters absent; all other behaviour identical.

Verification (N=32, ES=2)
REQ-029 in_data=32'h55555555, out_ready=1 -> 2 cycles later sign=0, k=0, exponent=2'b10, mantissa=32'hD5555550.
REQ-030 in_data=32'h775555FF -> sign=0, k=2, exponent=2'b11, mantissa=32'hD5557FC0.
REQ-031 in_data=32'hFFFFFFFF -> sign=1, k=-30, exponent=0, mantissa=32'h80000000, inf=0, zero=0.
REQ-032 in_data=32'h00000000 then 32'h80000000 back-to-back -> zero=1 then inf=1, each with k=0, mantissa=0; with STATS macro zero_count=1, nar_count=1.
REQ-033 Stream 8 tagged words with out_ready held 0 for 5 cycles mid-stream -> in_ready=0 once both stages full, outputs stable, all 8 tags out in order, none lost.
REQ-034 Assert rst for 1 cycle with 2 words in flight -> out_valid=0 immediately, neither word emitted, next accepted word out after 2 cycles.
